// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state types for the SRAM responder.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  // FIXED holds the word index; INCR and WRAP step it by one word per beat.
  function automatic logic burst_advances(input logic [1:0] burst);
    case (burst)
      BURST_FIXED: return 1'b0;
      BURST_INCR:  return 1'b1;
      BURST_WRAP:  return 1'b1;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// DEPTH x DATA_WIDTH single-clock RAM: one byte-enabled write port and one
// read port with a registered output that only updates when i_re is high.
module axi_sram_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 4096,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [STRB_WIDTH-1:0] i_wstrb,
  input  logic                  i_re,
  input  logic [IDX_W-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Byte-lane write: only lanes with a set strobe are updated.
  // NOTE: the array has no reset; clearing thousands of words would force it out of block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (i_wstrb[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  // Registered read; a same-cycle write to the same word is not visible yet.
  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 memory responder: one outstanding read and one outstanding write,
// independent read/write FSMs in front of a byte-enabled on-chip RAM.
module axi_sram_slave #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] S01_AXI_ARADDR,
  input  logic                  S01_AXI_ARVALID,
  input  logic [7:0]            S01_AXI_ARLEN,
  input  logic [ID_WIDTH-1:0]   S01_AXI_ARID,
  input  logic [2:0]            S01_AXI_ARSIZE,
  input  logic [1:0]            S01_AXI_ARBURST,
  output logic                  S01_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0] S01_AXI_RDATA,
  output logic                  S01_AXI_RLAST,
  output logic                  S01_AXI_RVALID,
  output logic [ID_WIDTH-1:0]   S01_AXI_RID,
  output logic [1:0]            S01_AXI_RRESP,
  input  logic                  S01_AXI_RREADY,
  input  logic [ADDR_WIDTH-1:0] S01_AXI_AWADDR,
  input  logic                  S01_AXI_AWVALID,
  input  logic [7:0]            S01_AXI_AWLEN,
  input  logic [ID_WIDTH-1:0]   S01_AXI_AWID,
  input  logic [2:0]            S01_AXI_AWSIZE,
  input  logic [1:0]            S01_AXI_AWBURST,
  output logic                  S01_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0] S01_AXI_WDATA,
  input  logic [STRB_WIDTH-1:0] S01_AXI_WSTRB,
  input  logic                  S01_AXI_WLAST,
  input  logic                  S01_AXI_WVALID,
  output logic                  S01_AXI_WREADY,
  output logic [ID_WIDTH-1:0]   S01_AXI_BID,
  output logic [1:0]            S01_AXI_BRESP,
  output logic                  S01_AXI_BVALID,
  input  logic                  S01_AXI_BREADY
);

  import axi_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  // Read path state
  rd_state_e           r_rstate;
  logic                r_arready, r_rvalid, r_rlast;
  logic [ID_WIDTH-1:0] r_rid;
  logic [7:0]          r_rlen, r_rcnt;
  logic [1:0]          r_rburst;
  logic [IDX_W-1:0]    r_ridx;

  // Write path state
  wr_state_e           r_wstate;
  logic                r_awready, r_wready, r_bvalid;
  logic [ID_WIDTH-1:0] r_bid;
  logic [1:0]          r_wburst;
  logic [IDX_W-1:0]    r_widx;

  logic                  w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_re;
  logic [IDX_W-1:0]      w_ar_idx, w_aw_idx, w_ridx_next, w_widx_next, w_raddr;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused;

  // Size fields, AWLEN and the address bits outside the word index carry no meaning here.
  assign w_unused = ^{S01_AXI_ARADDR, S01_AXI_AWADDR, S01_AXI_ARSIZE, S01_AXI_AWSIZE, S01_AXI_AWLEN};

  assign w_ar_hs     = S01_AXI_ARVALID & r_arready;
  assign w_r_hs      = r_rvalid & S01_AXI_RREADY;
  assign w_aw_hs     = S01_AXI_AWVALID & r_awready;
  assign w_w_hs      = S01_AXI_WVALID & r_wready;
  assign w_ar_idx    = S01_AXI_ARADDR[3 +: IDX_W];
  assign w_aw_idx    = S01_AXI_AWADDR[3 +: IDX_W];
  assign w_ridx_next = burst_advances(r_rburst) ? r_ridx + 1'b1 : r_ridx;
  assign w_widx_next = burst_advances(r_wburst) ? r_widx + 1'b1 : r_widx;

  // Fetch on AR accept (first beat) or on a beat accept with more to come;
  // otherwise the RAM output register holds, keeping RDATA stable under stall.
  assign w_re    = w_ar_hs | (w_r_hs & ~r_rlast);
  assign w_raddr = w_ar_hs ? w_ar_idx : w_ridx_next;

  axi_sram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_w_hs),
    .i_waddr (r_widx),
    .i_wdata (S01_AXI_WDATA),
    .i_wstrb (S01_AXI_WSTRB),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Read FSM: accept AR, then stream LEN+1 beats with no bubbles.
  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_rburst  <= BURST_FIXED;
      r_ridx    <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rid     <= S01_AXI_ARID;
            r_rlen    <= S01_AXI_ARLEN;
            r_rburst  <= S01_AXI_ARBURST;
            r_ridx    <= w_ar_idx;
            r_rcnt    <= '0;
            r_rvalid  <= 1'b1;
            r_rlast   <= (S01_AXI_ARLEN == 8'd0);
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_rcnt  <= r_rcnt + 8'd1;
              r_ridx  <= w_ridx_next;
              r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Write FSM: accept AW, take W beats until WLAST, then hold B until taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_wburst  <= BURST_FIXED;
      r_widx    <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (w_aw_hs) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_bid     <= S01_AXI_AWID;
            r_wburst  <= S01_AXI_AWBURST;
            r_widx    <= w_aw_idx;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_widx <= w_widx_next;
            if (S01_AXI_WLAST) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S01_AXI_BREADY) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign S01_AXI_ARREADY = r_arready;
  assign S01_AXI_RDATA   = w_rdata;
  assign S01_AXI_RLAST   = r_rlast;
  assign S01_AXI_RVALID  = r_rvalid;
  assign S01_AXI_RID     = r_rid;
  assign S01_AXI_RRESP   = RESP_OKAY;
  assign S01_AXI_AWREADY = r_awready;
  assign S01_AXI_WREADY  = r_wready;
  assign S01_AXI_BID     = r_bid;
  assign S01_AXI_BRESP   = RESP_OKAY;
  assign S01_AXI_BVALID  = r_bvalid;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: a word/byte-lane memory model with per-byte
// "known" flags, expected-beat queues checked by one negedge monitor, directed
// scenarios with literal expectations, and a randomized burst phase.
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] ARADDR, AWADDR, WDATA, RDATA;
  logic [7:0]  ARLEN, AWLEN, WSTRB;
  logic [3:0]  ARID, AWID, RID, BID;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

  always #5 clk = ~clk;

  axi_sram_slave dut (
    .clk(clk), .rst(rst),
    .S01_AXI_ARADDR(ARADDR), .S01_AXI_ARVALID(ARVALID), .S01_AXI_ARLEN(ARLEN),
    .S01_AXI_ARID(ARID), .S01_AXI_ARSIZE(ARSIZE), .S01_AXI_ARBURST(ARBURST),
    .S01_AXI_ARREADY(ARREADY),
    .S01_AXI_RDATA(RDATA), .S01_AXI_RLAST(RLAST), .S01_AXI_RVALID(RVALID),
    .S01_AXI_RID(RID), .S01_AXI_RRESP(RRESP), .S01_AXI_RREADY(RREADY),
    .S01_AXI_AWADDR(AWADDR), .S01_AXI_AWVALID(AWVALID), .S01_AXI_AWLEN(AWLEN),
    .S01_AXI_AWID(AWID), .S01_AXI_AWSIZE(AWSIZE), .S01_AXI_AWBURST(AWBURST),
    .S01_AXI_AWREADY(AWREADY),
    .S01_AXI_WDATA(WDATA), .S01_AXI_WSTRB(WSTRB), .S01_AXI_WLAST(WLAST),
    .S01_AXI_WVALID(WVALID), .S01_AXI_WREADY(WREADY),
    .S01_AXI_BID(BID), .S01_AXI_BRESP(BRESP), .S01_AXI_BVALID(BVALID),
    .S01_AXI_BREADY(BREADY)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural memory model ----------------
  logic [63:0] m_data  [4096];
  logic [7:0]  m_known [4096];

  function automatic int beat_idx(input logic [63:0] addr, input int beat, input logic [1:0] burst);
    logic [63:0] base;
    base = (addr >> 3) % 64'd4096;
    if (burst == 2'b00) return int'(base);
    return int'((base + 64'(beat)) % 64'd4096);
  endfunction

  function automatic logic [63:0] lane_mask(input logic [7:0] k);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  task automatic model_write(input int idx, input logic [63:0] d, input logic [7:0] s);
    for (int i = 0; i < 8; i++) begin
      if (s[i]) begin
        m_data[idx][8*i +: 8] = d[8*i +: 8];
        m_known[idx][i] = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic [63:0] data;
    logic [7:0]  known;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;

  rbeat_t      r_q[$];
  logic [3:0]  b_q[$];
  logic [63:0] got_q[$];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];

  function automatic logic [63:0] got(input int i);
    if (i < got_q.size()) return got_q[i];
    return 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  // ---------------- compare process ----------------
  logic        r_stall = 1'b0;
  logic [63:0] r_prev  = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (RVALID) begin
        if (r_q.size() == 0) begin
          check("r_unexpected_valid", RVALID, 1'b0);
        end else begin
          if (r_q[0].known != 8'h00)
            check("rdata", RDATA & lane_mask(r_q[0].known), r_q[0].data & lane_mask(r_q[0].known));
          check("rlast", RLAST, r_q[0].last);
          check("rid", RID, r_q[0].id);
          check("rresp", RRESP, 2'b00);
          if (RREADY) void'(r_q.pop_front());
        end
        if (r_stall) check("rdata_stable", RDATA, r_prev);
      end
      if (BVALID) begin
        if (b_q.size() == 0) begin
          check("b_unexpected_valid", BVALID, 1'b0);
        end else begin
          check("bid", BID, b_q[0]);
          check("bresp", BRESP, 2'b00);
          if (BREADY) void'(b_q.pop_front());
        end
      end
      r_stall <= RVALID && !RREADY;
      r_prev  <= RDATA;
    end else begin
      r_stall <= 1'b0;
    end
  end

  // ---------------- drivers ----------------
  // Waits (bounded) for the selected READY while the caller holds VALID; returns
  // at #1 after the handshake edge. waits counts cycles spent with READY low.
  task automatic wait_ready(input int sel, output int waits);
    logic r;
    r = 1'b0;
    waits = 0;
    while (!r && waits < 100) begin
      @(negedge clk);
      case (sel)
        0:       r = ARREADY;
        1:       r = AWREADY;
        default: r = WREADY;
      endcase
      @(posedge clk); #1;
      if (!r) waits++;
    end
  endtask

  task automatic wait_b(input int mode);
    int   c;
    logic done;
    c = 0;
    done = 1'b0;
    while (!done && c < 100) begin
      BREADY = (mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
      @(negedge clk);
      if (c == 0) check("bvalid_after_wlast", BVALID, 1'b1);
      if (BVALID && BREADY) done = 1'b1;
      @(posedge clk); #1;
      c++;
    end
    BREADY = 1'b0;
    check("b_done", done, 1'b1);
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] id, input int bmode);
    int w;
    AWADDR = addr; AWLEN = len; AWBURST = burst; AWID = id; AWSIZE = 3'd3; AWVALID = 1'b1;
    wait_ready(1, w);
    AWVALID = 1'b0;
    check("aw_accept_wait", w, 0);
    b_q.push_back(id);
    for (int b = 0; b <= int'(len); b++) begin
      WDATA = wd[b]; WSTRB = ws[b]; WLAST = (b == int'(len)); WVALID = 1'b1;
      wait_ready(2, w);
      if (w < 100) model_write(beat_idx(addr, b, burst), wd[b], ws[b]);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    wait_b(bmode);
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [3:0] id, input int rmode);
    int     w, cyc, beats, idx;
    rbeat_t e;
    got_q.delete();
    for (int b = 0; b <= int'(len); b++) begin
      idx = beat_idx(addr, b, burst);
      e.data = m_data[idx]; e.known = m_known[idx]; e.last = (b == int'(len)); e.id = id;
      r_q.push_back(e);
    end
    ARADDR = addr; ARLEN = len; ARBURST = burst; ARID = id; ARSIZE = 3'd3; ARVALID = 1'b1;
    wait_ready(0, w);
    ARVALID = 1'b0;
    check("ar_accept_wait", w, 0);
    cyc = 0; beats = 0;
    while (beats <= int'(len) && cyc < 2000) begin
      case (rmode)
        0:       RREADY = 1'b1;
        1:       RREADY = (cyc % 2 == 0);
        default: RREADY = ($urandom_range(1) == 1);
      endcase
      @(negedge clk);
      if (cyc == 0) check("rvalid_after_ar", RVALID, 1'b1);
      check("arready_busy", ARREADY, 1'b0);
      if (RVALID && RREADY) begin
        got_q.push_back(RDATA);
        beats++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    RREADY = 1'b0;
    check("r_beats", beats, int'(len) + 1);
    @(negedge clk);
    check("arready_after_burst", ARREADY, 1'b1);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    logic [63:0] a;
    logic [7:0]  l;
    for (int i = 0; i < 4096; i++) begin
      m_data[i] = '0;
      m_known[i] = '0;
    end
    ARADDR = '0; ARVALID = 0; ARLEN = '0; ARID = '0; ARSIZE = '0; ARBURST = '0; RREADY = 0;
    AWADDR = '0; AWVALID = 0; AWLEN = '0; AWID = '0; AWSIZE = '0; AWBURST = '0;
    WDATA = '0; WSTRB = '0; WLAST = 0; WVALID = 0; BREADY = 0;

    // 1) reset
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", ARREADY, 0); check("rst_awready", AWREADY, 0);
    check("rst_wready", WREADY, 0);   check("rst_rvalid", RVALID, 0);
    check("rst_bvalid", BVALID, 0);   check("rst_rlast", RLAST, 0);
    check("rst_rid", RID, 0);         check("rst_bid", BID, 0);
    check("rst_rresp", RRESP, 0);     check("rst_bresp", BRESP, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_arready", ARREADY, 1); check("post_rst_awready", AWREADY, 1);
    check("post_rst_wready", WREADY, 0);
    @(posedge clk); #1;

    // 2) single write then read
    wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
    do_write(64'h80, 8'd0, 2'b01, 4'h9, 0);
    do_read(64'h80, 8'd0, 2'b01, 4'h6, 0);
    check("t2_rdata", got(0), 64'h1122334455667788);

    // 3) byte strobes
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
    do_write(64'h88, 8'd0, 2'b01, 4'h1, 0);
    wd[0] = 64'h0; ws[0] = 8'h0F;
    do_write(64'h88, 8'd0, 2'b01, 4'h1, 1);
    wd[0] = 64'h0; ws[0] = 8'h00;
    do_write(64'h88, 8'd0, 2'b01, 4'h1, 0);
    do_read(64'h88, 8'd0, 2'b01, 4'h2, 0);
    check("t3_rdata", got(0), 64'hFFFF_FFFF_0000_0000);

    // 4) INCR burst LEN=3 with RREADY toggling
    for (int b = 0; b < 4; b++) begin
      wd[b] = 64'h4000_0000_0000_0100 + 64'(b * 8); ws[b] = 8'hFF;
    end
    do_write(64'h100, 8'd3, 2'b01, 4'h4, 0);
    do_read(64'h100, 8'd3, 2'b01, 4'h7, 1);
    check("t4_beat0", got(0), 64'h4000_0000_0000_0100);
    check("t4_beat1", got(1), 64'h4000_0000_0000_0108);
    check("t4_beat2", got(2), 64'h4000_0000_0000_0110);
    check("t4_beat3", got(3), 64'h4000_0000_0000_0118);

    // wrap at top of RAM, with aliasing upper address bits
    for (int b = 0; b < 4; b++) begin
      wd[b] = 64'h7700_0000_0000_0000 + 64'(b); ws[b] = 8'hFF;
    end
    do_write(64'hABCD_0000_0000_7FF0, 8'd3, 2'b01, 4'h3, 0);
    do_read(64'h7FF0, 8'd3, 2'b10, 4'h3, 2);
    do_read(64'h0, 8'd0, 2'b01, 4'h0, 0);
    check("wrap_idx0", got(0), 64'h7700_0000_0000_0002);

    // FIXED burst holds the index
    wd[0] = 64'hF0; wd[1] = 64'hF1; wd[2] = 64'hF2; ws[0] = 8'hFF; ws[1] = 8'hFF; ws[2] = 8'hFF;
    do_write(64'h400, 8'd2, 2'b00, 4'h8, 0);
    do_read(64'h400, 8'd1, 2'b00, 4'h8, 0);
    check("fixed_beat0", got(0), 64'hF2);
    check("fixed_beat1", got(1), 64'hF2);

    // 5) concurrent AR and AW to the same word
    wd[0] = 64'h5555_5555_5555_5555; ws[0] = 8'hFF;
    do_write(64'h200, 8'd0, 2'b01, 4'h0, 0);
    wd[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    fork
      do_write(64'h200, 8'd0, 2'b01, 4'h3, 1);
      do_read(64'h200, 8'd0, 2'b01, 4'h5, 1);
    join
    check("t5_old_data", got(0), 64'h5555_5555_5555_5555);
    do_read(64'h200, 8'd0, 2'b01, 4'h5, 0);
    check("t5_new_data", got(0), 64'hAAAA_AAAA_AAAA_AAAA);

    // 6) reset during beat 2 of a LEN=7 write
    for (int b = 0; b < 8; b++) begin
      wd[b] = 64'h0DD0_0000_0000_0000 + 64'(b); ws[b] = 8'hFF;
    end
    do_write(64'h300, 8'd7, 2'b01, 4'h1, 0);
    AWADDR = 64'h300; AWLEN = 8'd7; AWBURST = 2'b01; AWID = 4'h2; AWVALID = 1'b1;
    wait_ready(1, w);
    AWVALID = 1'b0;
    check("t6_aw_wait", w, 0);
    for (int b = 0; b < 2; b++) begin
      WDATA = 64'hBEEF_0000_0000_0000 + 64'(b); WSTRB = 8'hFF; WLAST = 1'b0; WVALID = 1'b1;
      wait_ready(2, w);
      if (w < 100) model_write(beat_idx(64'h300, b, 2'b01), WDATA, WSTRB);
    end
    WDATA = 64'hBEEF_0000_0000_0002; WVALID = 1'b1;
    #2 rst = 1'b0;
    WVALID = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("t6_no_bvalid", BVALID, 1'b0);
    end
    @(posedge clk); #1;
    do_read(64'h300, 8'd2, 2'b01, 4'hA, 0);
    check("t6_beat0", got(0), 64'hBEEF_0000_0000_0000);
    check("t6_beat1", got(1), 64'hBEEF_0000_0000_0001);
    check("t6_beat2", got(2), 64'h0DD0_0000_0000_0002);

    // randomized bursts against the model
    for (int k = 0; k < 60; k++) begin
      a = {$urandom(), $urandom()};
      if ($urandom_range(1) == 0) a[63:15] = '0;
      a[14:3] = 12'($urandom_range(63));
      l = 8'($urandom_range(7));
      if ($urandom_range(1) == 1) begin
        for (int b = 0; b <= int'(l); b++) begin
          wd[b] = {$urandom(), $urandom()};
          ws[b] = ($urandom_range(2) == 0) ? 8'($urandom()) : 8'hFF;
        end
        do_write(a, l, 2'($urandom_range(2)), 4'($urandom()), 1);
      end else begin
        do_read(a, l, 2'($urandom_range(2)), 4'($urandom()), $urandom_range(2));
      end
    end

    repeat (4) @(posedge clk);
    check("r_q_drained", r_q.size(), 0);
    check("b_q_drained", b_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
